pipe_flush_ctrl: RTL and testbench



---
 rtl/pipe_flush_ctrl.sv | 135 +++++++++++++
 tb/tb_pipe_flush_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_flush_ctrl.sv
// Pipeline redirect/flush arbiter with load-use stall, multi-cycle op stall
// FSM and wrong-path fetch-response drop counter for the 5-stage core.
//
// Ports:
//   clk, rst_n                    clock, synchronous active-low reset
//   ex_redirect/ex_target         EX resolved mispredict or jump
//   id_redirect/id_target/id_pc   ID early redirect and current ID PC
//   id_rs1/id_rs2/id_use_rs*      ID source operands
//   ex_mem_r/ex_rd/ex_md          EX load, destination, multi-cycle op
//   fetch_rsp_valid               instruction memory response strobe
//   pc_redirect/pc_target         PC mux control
//   pc_stall/if_id_stall/id_ex_stall, if_id_flush/id_ex_flush
//   fetch_drop                    discard current fetch response
//   md_busy                       multi-cycle FSM in BUSY
module pipe_flush_ctrl #(
  parameter int PC_WIDTH   = 32,
  parameter int REG_ADDR_W = 5,
  parameter int FETCH_LAT  = 1,
  parameter int MD_LAT     = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ex_redirect,
  input  logic [PC_WIDTH-1:0]   ex_target,
  input  logic                  id_redirect,
  input  logic [PC_WIDTH-1:0]   id_target,
  input  logic [PC_WIDTH-1:0]   id_pc,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic                  ex_mem_r,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_md,
  input  logic                  fetch_rsp_valid,
  output logic                  pc_redirect,
  output logic [PC_WIDTH-1:0]   pc_target,
  output logic                  pc_stall,
  output logic                  if_id_stall,
  output logic                  id_ex_stall,
  output logic                  if_id_flush,
  output logic                  id_ex_flush,
  output logic                  fetch_drop,
  output logic                  md_busy
);

  localparam int MW = (MD_LAT > 1) ? $clog2(MD_LAT) : 1;
  localparam int DW = (FETCH_LAT > 0) ? $clog2(FETCH_LAT + 1) : 1;
  localparam bit MD_MULTI = (MD_LAT > 1);
  localparam logic [MW-1:0] MD_LOAD =
    MW'(MD_MULTI ? MD_LAT - 2 : 0);
  localparam logic [DW-1:0] DROP_LOAD = DW'(FETCH_LAT);

  typedef enum logic {IDLE, BUSY} md_state_e;

  md_state_e       state_q, state_d;
  logic [MW-1:0]   md_cnt_q, md_cnt_d;
  logic [DW-1:0]   drop_cnt_q, drop_cnt_d;

  logic busy;
  logic ex_acc;
  logic id_acc;
  logic redir;
  logic lu_hz;
  logic md_start;
  logic md_stall;

  always_comb begin
    busy   = (state_q == BUSY);
    // Correct path already sitting in ID: no redirect, ID redirect ignored.
    ex_acc = ex_redirect && (id_pc != ex_target);
    id_acc = !ex_redirect && id_redirect && !busy;
    redir  = ex_acc || id_acc;
    lu_hz  = ex_mem_r && (ex_rd != '0) &&
             ((id_use_rs1 && (id_rs1 == ex_rd)) ||
              (id_use_rs2 && (id_rs2 == ex_rd)));
    md_start = MD_MULTI && !busy && ex_md && !ex_redirect;
    // Last BUSY cycle (count 0) lets the op leave EX.
    md_stall = md_start || (busy && (md_cnt_q != '0));
  end

  always_comb begin
    state_d    = state_q;
    md_cnt_d   = md_cnt_q;
    drop_cnt_d = drop_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (md_start) begin
          state_d  = BUSY;
          md_cnt_d = MD_LOAD;
        end
      end
      BUSY: begin
        if (md_cnt_q == '0) state_d = IDLE;
        else md_cnt_d = md_cnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
    // Reload, not accumulate: only responses since the latest redirect matter.
    if (redir) drop_cnt_d = DROP_LOAD;
    else if (fetch_rsp_valid && (drop_cnt_q != '0))
      drop_cnt_d = drop_cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      md_cnt_q   <= '0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      md_cnt_q   <= md_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  always_comb begin
    pc_redirect = rst_n && redir;
    unique case (1'b1)
      (rst_n && ex_acc): pc_target = ex_target;
      (rst_n && id_acc): pc_target = id_target;
      default:           pc_target = '0;
    endcase
    // Redirect beats load-use; the MD stall holds EX regardless.
    pc_stall    = rst_n && (md_stall || (lu_hz && !redir));
    if_id_stall = pc_stall;
    id_ex_stall = rst_n && md_stall;
    if_id_flush = rst_n && redir;
    id_ex_flush = rst_n &&
                  (ex_acc || (lu_hz && !redir && !md_stall));
    fetch_drop  = rst_n && (drop_cnt_q != '0) && fetch_rsp_valid;
    md_busy     = rst_n && busy;
  end

endmodule

// File: tb/tb_pipe_flush_ctrl.sv
// Testbench for pipe_flush_ctrl: vector table plus hand-written sequences,
// expected outputs queued at drive time and compared mid-cycle.
module tb_pipe_flush_ctrl;

  typedef struct packed {
    logic        rst_n;
    logic        exr;
    logic [31:0] ext;
    logic        idr;
    logic [31:0] idt;
    logic [31:0] idpc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        u1;
    logic        u2;
    logic        memr;
    logic [4:0]  rd;
    logic        md;
    logic        rsp;
  } in_t;

  // flag order: pcs ifs exs iff exf drop busy s1 b1
  // s1/b1 are pc_stall/md_busy of the MD_LAT=1 instance.
  typedef struct packed {
    logic        redir;
    logic [31:0] tgt;
    logic [8:0]  f;
  } out_t;

  typedef struct {
    string nm;
    in_t   i;
    out_t  o;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  in_t cur = '0;

  logic        pc_redirect, pc_stall, if_id_stall, id_ex_stall;
  logic        if_id_flush, id_ex_flush, fetch_drop, md_busy;
  logic [31:0] pc_target;
  logic        b_redirect, b_pc_stall, b_if_id_stall, b_id_ex_stall;
  logic        b_if_id_flush, b_id_ex_flush, b_fetch_drop, b_md_busy;
  logic [31:0] b_target;

  pipe_flush_ctrl #(.FETCH_LAT(2), .MD_LAT(4)) u0 (
    .clk(clk), .rst_n(cur.rst_n),
    .ex_redirect(cur.exr), .ex_target(cur.ext),
    .id_redirect(cur.idr), .id_target(cur.idt), .id_pc(cur.idpc),
    .id_rs1(cur.rs1), .id_rs2(cur.rs2),
    .id_use_rs1(cur.u1), .id_use_rs2(cur.u2),
    .ex_mem_r(cur.memr), .ex_rd(cur.rd), .ex_md(cur.md),
    .fetch_rsp_valid(cur.rsp),
    .pc_redirect(pc_redirect), .pc_target(pc_target),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall),
    .id_ex_stall(id_ex_stall), .if_id_flush(if_id_flush),
    .id_ex_flush(id_ex_flush), .fetch_drop(fetch_drop),
    .md_busy(md_busy)
  );

  pipe_flush_ctrl #(.FETCH_LAT(1), .MD_LAT(1)) u1 (
    .clk(clk), .rst_n(cur.rst_n),
    .ex_redirect(cur.exr), .ex_target(cur.ext),
    .id_redirect(cur.idr), .id_target(cur.idt), .id_pc(cur.idpc),
    .id_rs1(cur.rs1), .id_rs2(cur.rs2),
    .id_use_rs1(cur.u1), .id_use_rs2(cur.u2),
    .ex_mem_r(cur.memr), .ex_rd(cur.rd), .ex_md(cur.md),
    .fetch_rsp_valid(cur.rsp),
    .pc_redirect(b_redirect), .pc_target(b_target),
    .pc_stall(b_pc_stall), .if_id_stall(b_if_id_stall),
    .id_ex_stall(b_id_ex_stall), .if_id_flush(b_if_id_flush),
    .id_ex_flush(b_id_ex_flush), .fetch_drop(b_fetch_drop),
    .md_busy(b_md_busy)
  );

  out_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  function automatic out_t mo(input logic r, input logic [31:0] t,
                              input logic [8:0] f);
    out_t o;
    o.redir = r;
    o.tgt   = t;
    o.f     = f;
    return o;
  endfunction

  function automatic in_t idle();
    in_t x = '0;
    x.rst_n = 1'b1;
    return x;
  endfunction

  task automatic check(input string nm);
    out_t e, a;
    a = mo(pc_redirect, pc_target,
           {pc_stall, if_id_stall, id_ex_stall, if_id_flush,
            id_ex_flush, fetch_drop, md_busy, b_pc_stall, b_md_busy});
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL %s: scoreboard empty, got %h", nm, a);
    end else begin
      e = exp_q.pop_front();
      if (a !== e) begin
        bad++;
        $display("FAIL %s: got redir=%b tgt=%h f=%b, want redir=%b tgt=%h f=%b",
                 nm, a.redir, a.tgt, a.f, e.redir, e.tgt, e.f);
      end
    end
  endtask

  task automatic go(input string nm, input in_t x, input out_t o);
    cur = x;
    exp_q.push_back(o);
    @(negedge clk);
    check(nm);
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[$];

  task automatic add(input string nm, input in_t x, input out_t o);
    vec_t v;
    v.nm = nm;
    v.i  = x;
    v.o  = o;
    tbl.push_back(v);
  endtask

  initial begin
    in_t x;
    out_t z;
    z = mo(1'b0, 32'h0, 9'b0);

    x = idle(); x.rst_n = 1'b0; x.exr = 1'b1;
    x.ext = 32'h100; x.md = 1'b1;
    add("rst_forced", x, z);
    add("post_rst", idle(), z);
    x = idle(); x.exr = 1'b1; x.ext = 32'h100; x.idpc = 32'h40;
    add("ex_acc", x, mo(1'b1, 32'h100, 9'b000110000));
    x.idpc = 32'h100;
    add("ex_in_id", x, z);
    x = idle(); x.exr = 1'b1; x.ext = 32'h200; x.idpc = 32'h40;
    x.idr = 1'b1; x.idt = 32'h300;
    add("ex_over_id", x, mo(1'b1, 32'h200, 9'b000110000));
    x = idle(); x.idr = 1'b1; x.idt = 32'h300;
    add("id_acc", x, mo(1'b1, 32'h300, 9'b000100000));
    x.exr = 1'b1; x.ext = 32'h100; x.idpc = 32'h100;
    add("id_ignored", x, z);
    x = idle(); x.memr = 1'b1; x.rd = 5'd5;
    x.rs2 = 5'd5; x.u2 = 1'b1;
    add("lu_rs2", x, mo(1'b0, 32'h0, 9'b110010010));
    x.rd = 5'd0; x.rs2 = 5'd0;
    add("lu_x0", x, z);
    x = idle(); x.memr = 1'b1; x.rd = 5'd7;
    x.rs1 = 5'd7; x.u1 = 1'b1;
    add("lu_rs1", x, mo(1'b0, 32'h0, 9'b110010010));
    x.u1 = 1'b0;
    add("lu_unused", x, z);
    x.u1 = 1'b1; x.exr = 1'b1; x.ext = 32'h100; x.idpc = 32'h40;
    add("lu_ex_over", x, mo(1'b1, 32'h100, 9'b000110000));
    x.exr = 1'b0; x.idr = 1'b1; x.idt = 32'h300;
    add("lu_id_over", x, mo(1'b1, 32'h300, 9'b000100000));

    @(posedge clk);
    #1;
    foreach (tbl[k]) go(tbl[k].nm, tbl[k].i, tbl[k].o);

    // Multi-cycle op, MD_LAT=4: 3 stall cycles, 3 BUSY cycles.
    x = idle(); x.rst_n = 1'b0;
    go("md_rst", x, z);
    x = idle(); x.md = 1'b1;
    go("md_start", x, mo(1'b0, 32'h0, 9'b111000000));
    x = idle(); x.memr = 1'b1; x.rd = 5'd5;
    x.rs2 = 5'd5; x.u2 = 1'b1;
    go("md_busy_lu", x, mo(1'b0, 32'h0, 9'b111000110));
    x = idle(); x.idr = 1'b1; x.idt = 32'h300;
    go("md_busy_idr", x, mo(1'b0, 32'h0, 9'b111000100));
    go("md_last", idle(), mo(1'b0, 32'h0, 9'b000000100));
    go("md_done", idle(), z);

    // Reset in the second cycle aborts BUSY.
    x = idle(); x.md = 1'b1;
    go("md2_start", x, mo(1'b0, 32'h0, 9'b111000000));
    x = idle(); x.rst_n = 1'b0;
    go("md2_rst", x, z);
    go("md2_after", idle(), z);

    // Fetch drop, FETCH_LAT=2.
    x = idle(); x.exr = 1'b1; x.ext = 32'h100;
    x.idpc = 32'h40; x.rsp = 1'b1;
    go("dr_redir", x, mo(1'b1, 32'h100, 9'b000110000));
    x = idle(); x.rsp = 1'b1;
    go("dr_1", x, mo(1'b0, 32'h0, 9'b000001000));
    go("dr_2", x, mo(1'b0, 32'h0, 9'b000001000));
    go("dr_3", x, z);
    x.idr = 1'b1; x.idt = 32'h300;
    go("dr_id", x, mo(1'b1, 32'h300, 9'b000100000));
    go("dr_norsp", idle(), z);
    x = idle(); x.rsp = 1'b1;
    go("dr_4", x, mo(1'b0, 32'h0, 9'b000001000));
    x.exr = 1'b1; x.ext = 32'h100; x.idpc = 32'h40;
    go("dr_reload", x, mo(1'b1, 32'h100, 9'b000111000));
    x = idle(); x.rsp = 1'b1;
    go("dr_5", x, mo(1'b0, 32'h0, 9'b000001000));
    go("dr_6", x, mo(1'b0, 32'h0, 9'b000001000));
    go("dr_7", x, z);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
